// File: rtl/ex_operand_stage_pkg.sv
// Shared types and constants for the EX operand stage: source selects, ALU codes,
// the poison operand and the forwarding hit test.
package ex_operand_stage_pkg;

    typedef enum logic [1:0] {
        SrcaRs1  = 2'd0,
        SrcaPc   = 2'd1,
        SrcaImm  = 2'd2,
        SrcaRsvd = 2'd3
    } srca_sel_e;

    typedef enum logic {
        SrcbRs2 = 1'b0,
        SrcbImm = 1'b1
    } srcb_sel_e;

    localparam logic [3:0] AluAdd  = 4'h0;
    localparam logic [3:0] AluSub  = 4'h1;
    localparam logic [3:0] AluSll  = 4'h2;
    localparam logic [3:0] AluSlt  = 4'h3;
    localparam logic [3:0] AluSltu = 4'h4;
    localparam logic [3:0] AluXor  = 4'h5;
    localparam logic [3:0] AluSrl  = 4'h6;
    localparam logic [3:0] AluSra  = 4'h7;
    localparam logic [3:0] AluOr   = 4'h8;
    localparam logic [3:0] AluAnd  = 4'h9;
    localparam logic [3:0] AluCopy = 4'hA;

    // Loaded into SRC_A for the reserved source select so misuse is visible downstream.
    localparam logic [31:0] PoisonWord = 32'hDEADDEAD;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Bypass select for one source register: MEM result, else WB result, else register file.
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    always_comb begin
        fwd_data = rs_data;
        if (fwd_hit(mem_we, mem_rd, rs_addr)) begin
            fwd_data = mem_data;
        end else if (fwd_hit(wb_we, wb_rd, rs_addr)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// EX operand stage: resolves forwarding at capture, selects ALU operands and holds them
// in a one-entry valid/ready register with a saturating back-pressure counter.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [1:0]      in_srca_sel,
    input  logic            in_srcb_sel,
    input  logic [3:0]      in_alu_fun,
    input  logic            in_reg_we,
    input  logic            fwd_mem_we,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] src_a,
    output logic [XLEN-1:0] src_b,
    output logic [3:0]      alu_fun,
    output logic [4:0]      out_rd_addr,
    output logic            out_reg_we,
    output logic [CNTW-1:0] stall_cnt
);

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] src_a_d, src_b_d;
    logic            capture;

    logic            out_valid_q;
    logic [XLEN-1:0] src_a_q, src_b_q;
    logic [3:0]      alu_fun_q;
    logic [4:0]      rd_addr_q;
    logic            reg_we_q;
    logic [CNTW-1:0] stall_cnt_q;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr  (in_rs1_addr),
        .rs_data  (in_rs1_data),
        .mem_we   (fwd_mem_we),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .wb_we    (fwd_wb_we),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .fwd_data (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr  (in_rs2_addr),
        .rs_data  (in_rs2_data),
        .mem_we   (fwd_mem_we),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .wb_we    (fwd_wb_we),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .fwd_data (rs2_fwd)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        src_a_d = rs1_fwd;
        unique case (srca_sel_e'(in_srca_sel))
            SrcaRs1:  src_a_d = rs1_fwd;
            SrcaPc:   src_a_d = in_pc;
            SrcaImm:  src_a_d = in_imm;
            SrcaRsvd: src_a_d = XLEN'(PoisonWord);
            default:  src_a_d = rs1_fwd;
        endcase
        src_b_d = (srcb_sel_e'(in_srcb_sel) == SrcbImm) ? in_imm : rs2_fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            alu_fun_q   <= 4'b0000;
            rd_addr_q   <= 5'd0;
            reg_we_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            // Flush wins over both capture and drain; payload is left as-is.
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (capture) begin
                out_valid_q <= 1'b1;
                src_a_q     <= src_a_d;
                src_b_q     <= src_b_d;
                alu_fun_q   <= in_alu_fun;
                rd_addr_q   <= in_rd_addr;
                reg_we_q    <= in_reg_we;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign src_a       = src_a_q;
    assign src_b       = src_b_q;
    assign alu_fun     = alu_fun_q;
    assign out_rd_addr = rd_addr_q;
    assign out_reg_we  = reg_we_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: vector table through a scoreboard plus
// hand-written stall, flush, drain, saturation and reset sequences.
module tb_ex_operand_stage;

    typedef struct {
        logic [1:0]  srca;
        logic        srcb;
        logic [4:0]  rs1a;
        logic [31:0] rs1d;
        logic [4:0]  rs2a;
        logic [31:0] rs2d;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [3:0]  fun;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fun;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [1:0]  in_srca_sel;
    logic        in_srcb_sel;
    logic [3:0]  in_alu_fun;
    logic        in_reg_we;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] src_a, src_b;
    logic [3:0]  alu_fun;
    logic [4:0]  out_rd_addr;
    logic        out_reg_we;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_out_reg_we;
    logic [31:0] s_src_a, s_src_b;
    logic [3:0]  s_alu_fun;
    logic [4:0]  s_out_rd_addr;
    logic [2:0]  s_stall_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[8];
    exp_t sb[$];

    ex_operand_stage #(.XLEN(32), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_pc(in_pc), .in_imm(in_imm), .in_srca_sel(in_srca_sel), .in_srcb_sel(in_srcb_sel),
        .in_alu_fun(in_alu_fun), .in_reg_we(in_reg_we),
        .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we), .fwd_mem_rd(fwd_mem_rd),
        .fwd_wb_rd(fwd_wb_rd), .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .src_a(src_a), .src_b(src_b), .alu_fun(alu_fun), .out_rd_addr(out_rd_addr),
        .out_reg_we(out_reg_we), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    ex_operand_stage #(.XLEN(32), .CNTW(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_pc(in_pc), .in_imm(in_imm), .in_srca_sel(in_srca_sel), .in_srcb_sel(in_srcb_sel),
        .in_alu_fun(in_alu_fun), .in_reg_we(in_reg_we),
        .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we), .fwd_mem_rd(fwd_mem_rd),
        .fwd_wb_rd(fwd_wb_rd), .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .src_a(s_src_a), .src_b(s_src_b), .alu_fun(s_alu_fun), .out_rd_addr(s_out_rd_addr),
        .out_reg_we(s_out_reg_we), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0;
        in_rs1_data = '0; in_rs2_data = '0; in_pc = '0; in_imm = '0;
        in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
        in_srca_sel = '0; in_srcb_sel = 1'b0; in_alu_fun = '0; in_reg_we = 1'b0;
        fwd_mem_we = 1'b0; fwd_wb_we = 1'b0; fwd_mem_rd = '0; fwd_wb_rd = '0;
        fwd_mem_data = '0; fwd_wb_data = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        in_valid = 1'b1;
        in_srca_sel = v.srca; in_srcb_sel = v.srcb;
        in_rs1_addr = v.rs1a; in_rs1_data = v.rs1d;
        in_rs2_addr = v.rs2a; in_rs2_data = v.rs2d;
        in_pc = v.pc; in_imm = v.imm;
        fwd_mem_we = v.mwe; fwd_mem_rd = v.mrd; fwd_mem_data = v.mdata;
        fwd_wb_we = v.wwe; fwd_wb_rd = v.wrd; fwd_wb_data = v.wdata;
        in_alu_fun = v.fun; in_rd_addr = v.rd; in_reg_we = v.we;
    endtask

    function automatic exp_t exp_of(input vec_t v);
        exp_t e;
        e.a = v.exp_a; e.b = v.exp_b; e.fun = v.fun; e.rd = v.rd; e.we = v.we;
        return e;
    endfunction

    task automatic check_front(input string tag);
        exp_t e;
        check({tag, ".out_valid"}, 64'(out_valid), 64'(1'b1));
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s.scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb[0];
            check({tag, ".src_a"},   64'(src_a),       64'(e.a));
            check({tag, ".src_b"},   64'(src_b),       64'(e.b));
            check({tag, ".alu_fun"}, 64'(alu_fun),     64'(e.fun));
            check({tag, ".rd"},      64'(out_rd_addr), 64'(e.rd));
            check({tag, ".reg_we"},  64'(out_reg_we),  64'(e.we));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid),   64'(0));
        check({tag, ".src_a"},     64'(src_a),       64'(0));
        check({tag, ".src_b"},     64'(src_b),       64'(0));
        check({tag, ".alu_fun"},   64'(alu_fun),     64'(0));
        check({tag, ".rd"},        64'(out_rd_addr), 64'(0));
        check({tag, ".reg_we"},    64'(out_reg_we),  64'(0));
        check({tag, ".stall_cnt"}, 64'(stall_cnt),   64'(0));
        check({tag, ".sat_zero"},  64'({s_out_valid, s_src_a, s_src_b, s_alu_fun,
                                        s_out_rd_addr, s_out_reg_we, s_stall_cnt}), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        //             srca srcb rs1a rs1d  rs2a rs2d pc imm mwe mrd mdata wwe wrd wdata fun rd we a b
        vecs[0] = '{2'd0, 1'b1, 5'd5, 32'h10, 5'd6, 32'h20, 32'h100, 32'h4,
                    1'b1, 5'd5, 32'h99, 1'b0, 5'd0, 32'h0, 4'h0, 5'd10, 1'b1, 32'h99, 32'h4};
        vecs[1] = '{2'd1, 1'b0, 5'd1, 32'h11, 5'd7, 32'h22, 32'h1000, 32'h8,
                    1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 4'h1, 5'd11, 1'b1, 32'h1000, 32'hAA};
        vecs[2] = '{2'd0, 1'b0, 5'd0, 32'h55, 5'd0, 32'h66, 32'h2000, 32'h0,
                    1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88, 4'h2, 5'd0, 1'b0, 32'h55, 32'h66};
        vecs[3] = '{2'd0, 1'b1, 5'd3, 32'h1, 5'd4, 32'h2, 32'h3000, 32'hFFFF_FFF0,
                    1'b1, 5'd4, 32'hCC, 1'b1, 5'd3, 32'hDD, 4'h7, 5'd12, 1'b1, 32'hDD, 32'hFFFF_FFF0};
        vecs[4] = '{2'd0, 1'b0, 5'd3, 32'h123, 5'd3, 32'h456, 32'h0, 32'h0,
                    1'b0, 5'd3, 32'hEE, 1'b0, 5'd3, 32'hFF, 4'h5, 5'd13, 1'b1, 32'h123, 32'h456};
        vecs[5] = '{2'd2, 1'b0, 5'd8, 32'h9, 5'd9, 32'h10, 32'h40, 32'hABCD,
                    1'b1, 5'd8, 32'h31, 1'b1, 5'd9, 32'h32, 4'hA, 5'd14, 1'b0, 32'hABCD, 32'h32};
        vecs[6] = '{2'd3, 1'b1, 5'd5, 32'h1, 5'd5, 32'h2, 32'h50, 32'h77,
                    1'b1, 5'd5, 32'h3, 1'b0, 5'd0, 32'h0, 4'hF, 5'd31, 1'b1, 32'hDEADDEAD, 32'h77};
        vecs[7] = '{2'd0, 1'b0, 5'd2, 32'h1, 5'd2, 32'h1, 32'h0, 32'h0,
                    1'b1, 5'd2, 32'h5A5A5A5A, 1'b1, 5'd2, 32'h11111111, 4'h3, 5'd1, 1'b1,
                    32'h5A5A5A5A, 32'h5A5A5A5A};

        idle_inputs();
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one capture per cycle, downstream always ready.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1 check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(1));
            sb.push_back(exp_of(vecs[i]));
            @(posedge clk);
            #1 check_front($sformatf("vec%0d", i));
            void'(sb.pop_front());
        end

        // Back-pressure: held entry frozen for 5 cycles while a new one waits.
        do_reset();
        @(negedge clk);
        apply_vec(vecs[0]);
        sb.push_back(exp_of(vecs[0]));
        @(posedge clk);
        #1 check_front("stall.first");
        @(negedge clk);
        apply_vec(vecs[1]);
        out_ready = 1'b0;
        #1 check("stall.in_ready", 64'(in_ready), 64'(0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1 check_front($sformatf("stall.c%0d", c));
            check($sformatf("stall.c%0d.in_ready", c), 64'(in_ready), 64'(0));
        end
        check("stall.cnt5", 64'(stall_cnt), 64'(5));
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("stall.release.in_ready", 64'(in_ready), 64'(1));
        void'(sb.pop_front());
        sb.push_back(exp_of(vecs[1]));
        @(posedge clk);
        #1 check_front("stall.next");
        check("stall.cnt_hold", 64'(stall_cnt), 64'(5));

        // Flush with a held entry and a stalled incoming one.
        @(negedge clk);
        out_ready = 1'b0;
        apply_vec(vecs[2]);
        flush = 1'b1;
        @(posedge clk);
        #1 check("flush.out_valid", 64'(out_valid), 64'(0));
        check("flush.payload_hold", 64'(src_a), 64'(vecs[1].exp_a));
        check("flush.cnt", 64'(stall_cnt), 64'(6));
        void'(sb.pop_front());
        // Flush also blocks capture when the stage is empty.
        @(negedge clk);
        out_ready = 1'b1;
        apply_vec(vecs[3]);
        flush = 1'b1;
        #1 check("flush2.in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 check("flush2.out_valid", 64'(out_valid), 64'(0));
        check("flush2.payload_hold", 64'(src_b), 64'(vecs[1].exp_b));

        // Drain without capture clears valid and keeps payload.
        @(negedge clk);
        flush = 1'b0;
        apply_vec(vecs[4]);
        sb.push_back(exp_of(vecs[4]));
        @(posedge clk);
        #1 check_front("drain.cap");
        void'(sb.pop_front());
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 check("drain.out_valid", 64'(out_valid), 64'(0));
        check("drain.payload_hold", 64'(src_a), 64'(vecs[4].exp_a));

        // Saturation on the narrow counter, then asynchronous reset mid-stall.
        do_reset();
        @(negedge clk);
        apply_vec(vecs[5]);
        sb.push_back(exp_of(vecs[5]));
        @(posedge clk);
        #1 check_front("sat.cap");
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("sat.wide_cnt", 64'(stall_cnt), 64'(10));
        check("sat.narrow_cnt", 64'(s_stall_cnt), 64'(7));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        apply_vec(vecs[6]);
        sb.push_back(exp_of(vecs[6]));
        @(posedge clk);
        #1 check_front("post_reset");
        check("post_reset.cnt", 64'(stall_cnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNTW, default 16, stall-counter width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 IN_VALID  in  1  decode stage offers an instruction.
REQ-007 IN_READY  out  1  stage can accept this cycle.
REQ-008 IN_RS1_DATA, IN_RS2_DATA  in  XLEN  register-file read data.
REQ-009 IN_RS1_ADDR, IN_RS2_ADDR, IN_RD_ADDR  in  5  source and destination register indices.
REQ-010 IN_PC, IN_IMM  in  XLEN  instruction PC and sign-extended immediate.
REQ-011 IN_SRCA_SEL  in  2  0=rs1, 1=PC, 2=IMM, 3=reserved.
REQ-012 IN_SRCB_SEL  in  1  0=rs2, 1=IMM.
REQ-013 IN_ALU_FUN  in  4  ALU operation code, passed unmodified.
REQ-014 IN_REG_WE  in  1  instruction writes rd.
REQ-015 FWD_MEM_WE, FWD_WB_WE  in  1  downstream stages will write a register.
REQ-016 FWD_MEM_RD, FWD_WB_RD  in  5  downstream destination indices.
REQ-017 FWD_MEM_DATA, FWD_WB_DATA  in  XLEN  downstream results.
REQ-018 FLUSH  in  1  discard held and incoming instruction.
REQ-019 OUT_VALID  out  1  SRC_A/SRC_B/ALU_FUN valid for the ALU.
REQ-020 OUT_READY  in  1  downstream consumes this cycle.
REQ-021 SRC_A, SRC_B  out  XLEN  registered ALU operands.
REQ-022 ALU_FUN  out  4  registered ALU operation code.
REQ-023 OUT_RD_ADDR  out  5; OUT_REG_WE  out  1  registered writeback tags.
REQ-024 STALL_CNT  out  CNTW  count of back-pressured cycles.

Function
REQ-025 IN_READY SHALL equal (!OUT_VALID || OUT_READY), combinationally.
REQ-026 Capture SHALL occur on a clock edge where IN_VALID && IN_READY && !FLUSH; all payload outputs load and OUT_VALID becomes 1; latency is one cycle.
REQ-027 Edge with OUT_VALID && OUT_READY and no capture SHALL clear OUT_VALID; payload outputs SHALL hold.
REQ-028 While OUT_VALID && !OUT_READY, all outputs SHALL remain stable.
REQ-029 Forwarded rsN SHALL be FWD_MEM_DATA if FWD_MEM_WE && FWD_MEM_RD!=0 && FWD_MEM_RD==IN_RSN_ADDR; else FWD_WB_DATA under same rule for WB; else IN_RSN_DATA.
REQ-030 MEM forwarding SHALL take priority over WB when both match; index 0 SHALL never forward.
REQ-031 Forwarding SHALL be resolved in the capture cycle, not the output cycle.
REQ-032 SRC_A SHALL load forwarded rs1 / IN_PC / IN_IMM per IN_SRCA_SEL; select 3 SHALL load 32'hDEADDEAD.
REQ-033 SRC_B SHALL load forwarded rs2 or IN_IMM per IN_SRCB_SEL.
REQ-034 FLUSH SHALL clear OUT_VALID at the next edge and block capture that edge, overriding both REQ-026 and REQ-027; payload SHALL hold.
REQ-035 STALL_CNT SHALL increment each edge with OUT_VALID && !OUT_READY, saturating at all-ones.

Reset
REQ-036 RST_N low SHALL immediately force OUT_VALID=0, SRC_A=0, SRC_B=0, ALU_FUN=4'b0000, OUT_RD_ADDR=0, OUT_REG_WE=0, STALL_CNT=0.
REQ-037 Reset mid-stall SHALL drop the held instruction; first capture after release behaves per REQ-026.

Structure
REQ-038 Shared package SHALL hold SRCA_SEL/SRCB_SEL enums, ALU_FUN code constants, and the 32'hDEADDEAD poison constant.
REQ-039 Forwarding compare/select SHALL be one sub-module, fwd_mux, instantiated for rs1 and rs2.

Verification
REQ-040 rs1=x5 data 0x10, FWD_MEM rd=5 data 0x99, SRCA_SEL=0 -> next cycle SRC_A=0x99, OUT_VALID=1.
REQ-041 MEM and WB both rd=7 (0xAA/0xBB), rs2=x7 -> SRC_B=0xAA; rd=0 with WE=1 -> no forwarding.
REQ-042 OUT_READY=0 for 5 cycles with new IN_VALID -> IN_READY=0, outputs frozen, STALL_CNT=5.
REQ-043 FLUSH with IN_VALID=1 and held instruction -> OUT_VALID=0 next cycle, no capture.
REQ-044 SRCA_SEL=3 -> SRC_A=32'hDEADDEAD; RST_N low mid-stall -> all outputs zero asynchronously.
